// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT datapath reorder buffers.
// Holds the bit-rotation used for stride permutation and the buffer FSM encoding.
package fft_buf_pkg;

  localparam int unsigned ROT_MAX_W = 32;
  localparam int unsigned ROT_IDX_W = $clog2(ROT_MAX_W);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } buf_state_t;

  // Rotate the low 'width' bits of value left by 'amount'; bits above width return 0.
  function automatic logic [ROT_MAX_W-1:0] rot_left(
    input logic [ROT_MAX_W-1:0] value,
    input int unsigned          amount,
    input int unsigned          width
  );
    logic [ROT_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < width; i++) begin
      res[ROT_IDX_W'((i + amount) % width)] = value[ROT_IDX_W'(i)];
    end
    return res;
  endfunction

  function automatic bit params_legal(
    input int unsigned depth_log2,
    input int unsigned stride_log2
  );
    return (depth_log2 >= 2) && (depth_log2 <= ROT_MAX_W) &&
           (stride_log2 >= 1) && (stride_log2 < depth_log2);
  endfunction

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port RAM, synchronous read-first: a write returns the previous
// content of the same address on rdata.
module sp_ram_rf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/stride_perm_buffer.sv
// In-place streaming stride-permutation buffer: one frame of RAM holds the
// incoming frame while the previous one is read out in rotated order.
module stride_perm_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned STRIDE_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  ctrl_in,
  input  logic                  perm_en,
  input  logic                  flush,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  ctrl_out,
  output logic                  err
);
  import fft_buf_pkg::*;

  if (!params_legal(DEPTH_LOG2, STRIDE_LOG2)) begin : g_param_check
    $error("stride_perm_buffer: requires DEPTH_LOG2 >= 2 and 1 <= STRIDE_LOG2 < DEPTH_LOG2");
  end

  localparam int unsigned     RW          = $clog2(DEPTH_LOG2);
  localparam logic [RW:0]     STRIDE_STEP = (RW+1)'(STRIDE_LOG2);
  localparam logic [RW:0]     ROT_MOD     = (RW+1)'(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] J_ONE = DEPTH_LOG2'(1);

  buf_state_t            state;
  logic [DEPTH_LOG2-1:0] j;
  logic [RW-1:0]         r;
  logic                  primed;

  logic                  accept, start, abort, drop, go_drain;
  logic                  wr_word, rd_en, rd_valid, rd_first;
  logic [RW:0]           r_step, r_sum;
  logic [RW-1:0]         r_adv, r_eff;
  logic [DEPTH_LOG2-1:0] j_eff, addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid_q, rd_first_q;

  // Each frame's rotation is relative to the previous one, so reading the
  // address being overwritten yields the prior frame in stride order.
  always_comb begin
    accept   = valid_in && in_ready;
    start    = accept && ctrl_in;
    abort    = start && (state == FILL);
    drop     = accept && !ctrl_in && (state == IDLE);
    go_drain = flush && primed && (state == IDLE) && !start;
    wr_word  = start || (accept && (state == FILL));
    rd_en    = wr_word || (state == DRAIN);

    r_step = '0;
    if (start) begin
      r_step = perm_en ? STRIDE_STEP : '0;
    end else if (go_drain) begin
      r_step = STRIDE_STEP;
    end
    r_sum = {1'b0, r} + r_step;
    r_adv = (r_sum >= ROT_MOD) ? RW'(r_sum - ROT_MOD) : r_sum[RW-1:0];

    r_eff = start ? r_adv : r;
    j_eff = start ? '0 : j;
    addr  = DEPTH_LOG2'(rot_left(ROT_MAX_W'(j_eff), 32'(r_eff), DEPTH_LOG2));

    rd_valid = (wr_word && primed && !abort) || (state == DRAIN);
    rd_first = rd_valid && (j_eff == '0);
  end

  sp_ram_rf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (rd_en),
    .we   (wr_word),
    .addr (addr),
    .wdata(data_in),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      j          <= '0;
      r          <= '0;
      primed     <= 1'b0;
      in_ready   <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      ctrl_out   <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= abort || drop;
      rd_valid_q <= rd_valid;
      rd_first_q <= rd_first;
      valid_out  <= rd_valid_q;
      ctrl_out   <= rd_first_q;
      if (rd_valid_q) begin
        data_out <= rdata;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            j     <= J_ONE;
            r     <= r_adv;
          end else if (go_drain) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
            j        <= '0;
            r        <= r_adv;
          end
        end
        FILL: begin
          if (start) begin
            j      <= J_ONE;
            r      <= r_adv;
            primed <= 1'b0;
          end else if (accept) begin
            j <= j + J_ONE;
            if (j == '1) begin
              state  <= IDLE;
              primed <= 1'b1;
            end
          end
        end
        DRAIN: begin
          j <= j + J_ONE;
          if (j == '1) begin
            state    <= IDLE;
            primed   <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stride_perm_buffer.md
# stride_perm_buffer

In-place streaming stride-permutation buffer for the FFT datapath, generalised over data width, frame depth and stride. Each frame of 2^DEPTH_LOG2 words is written into a single-port read-first RAM while the previous frame is read out of the same addresses, so one RAM of one frame holds both. The output order is a bit-rotation stride permutation, selectable per frame. The block sits between butterfly stages and supports input stalls, an explicit end-of-stream drain and a per-frame bypass.

## Interface
- DATA_WIDTH, 32, word width.
- DEPTH_LOG2, 4, log2 of frame length D; D=16 is a 64-point FFT split over 4 channels.
- STRIDE_LOG2, 2, log2 of stride S; range 1..DEPTH_LOG2-1.

- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- data_in  in  DATA_WIDTH  input word.
- valid_in  in  1  data_in is offered this cycle; it is accepted only when in_ready=1.
- ctrl_in  in  1  first word of a frame; meaningful only on an accepted word.
- perm_en  in  1  sampled with ctrl_in: 1 = permute, 0 = natural order.
- flush  in  1  single-cycle request to drain the stored frame.
- in_ready  out  1  the block accepts input words.
- data_out  out  DATA_WIDTH  output word.
- valid_out  out  1  data_out is valid.
- ctrl_out  out  1  first word of an output frame.
- err  out  1  one-cycle pulse on a framing error.

## Operation
- State: word counter j (DEPTH_LOG2 bits), rotation register r (mod DEPTH_LOG2), primed flag, FSM {IDLE, FILL, DRAIN}.
- Accepted word j of the current frame is written to address rot_left(j, r) over DEPTH_LOG2 bits. The RAM reads the old content at that address in the same cycle (read-first).
- At each accepted ctrl_in: r <= r + (perm_en ? STRIDE_LOG2 : 0) mod DEPTH_LOG2, taking effect for word 0 of this frame; j restarts at 0.
- Resulting output: word j of the emitted frame is input element rot_left(j, STRIDE_LOG2) of the previous frame when perm_en=1, and element j when perm_en=0. perm_en sampled with frame k selects the order of the frame emitted during frame k, which is frame k-1.
- primed is set when a frame completes (j wraps from D-1 to 0). Reads produce valid_out only while primed=1, so the first frame after reset emits nothing.
- FSM transitions:
  - IDLE -> FILL on an accepted ctrl_in.
  - FILL -> IDLE when j wraps.
  - IDLE -> DRAIN on flush with primed=1.
  - DRAIN -> IDLE after D reads.
- DRAIN behaviour:
  - in_ready=0.
  - The block internally steps j from 0 to D-1 at one word per cycle, with the RAM write disabled and r advanced as if perm_en=1 on entry.
  - The stored frame is emitted and primed clears on exit.
- Stalls: with valid_in=0 in FILL, j, r and the RAM hold and no output is produced.
- Framing errors, each giving err=1 for one cycle:
  - An accepted ctrl_in while j≠0 in FILL aborts the frame: primed clears, the new frame starts at j=0, and emission of the partial frame stops.
  - An accepted word without ctrl_in in IDLE is dropped.
- flush in FILL or with primed=0 is ignored.
- Reset mid-frame: all state returns to reset values. RAM contents are don't-care because primed=0.

## Timing
- Reset values:
  - Outputs: in_ready=1, data_out=0, valid_out=0, ctrl_out=0, err=0.
  - Internal state: j=0, r=0, primed=0, FSM=IDLE.
- Latency is 1 cycle: the word accepted (or drained) at edge t appears on data_out/valid_out after edge t+1. All outputs are registered.
- ctrl_out coincides with the output word for j=0.
- In steady state, with valid_in=1 continuously, an input frame and the output of the previous frame overlap exactly, giving a throughput of 1 word per cycle.
- in_ready falls in the cycle after flush is accepted and rises in the cycle after the last drain read.
- flush and an accepted ctrl_in in the same cycle in IDLE: ctrl_in wins and flush is ignored.

## Structure
- Shared package fft_buf_pkg holds:
  - the rot_left(value, amount, width) function;
  - the FSM state enum {IDLE, FILL, DRAIN};
  - the parameter legality checks, STRIDE_LOG2 < DEPTH_LOG2 and DEPTH_LOG2 ≥ 2.
- Sub-module sp_ram_rf: single-port, read-first, synchronous read, parametrised by DATA_WIDTH and DEPTH_LOG2, with no reset on the array.

## Test plan
- Two-frame transpose: defaults, frame 0 = 0..15, then frame 1 = 16..31 continuous with perm_en=1 -> during frame 1, out = 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; ctrl_out on the first word; nothing emitted during frame 0.
- Bypass: the same stimulus with perm_en=0 on frame 1 -> out = 0..15 in order. Then frame 2 with perm_en=1 -> frame 1 is emitted transposed (16,20,24,…).
- Stall: valid_in toggling 1,0,1,0 through frames 0 and 1 -> the same permuted sequence as the transpose case, valid_out pulses exactly 1 cycle after each accepted word, and no duplicates.
- Drain: after frame 0, pulse flush -> in_ready=0 for 16 cycles, out = 0,4,8,…,15 in transpose order, then in_ready=1 and primed=0 (a further flush produces no output).
- Framing error: ctrl_in again at j=5 of frame 1 -> err pulse, output stops after 5 words, and the next full frame emits nothing (primed cleared).
- Async reset mid-frame 1 at j=7: in_ready=1 and all other outputs 0 immediately. Two fresh frames then reproduce the transpose case exactly. Repeat with DEPTH_LOG2=6, STRIDE_LOG2=2: out word j = element rot_left(j,2) over 6 bits.
